// File: rtl/sm83_pkg.sv
// Shared types for the SM83 register file: register views, write-enable
// vector, register selectors and the IDU operation/target encodings.
package sm83_pkg;

    typedef logic [7:0]  r8_t;
    typedef logic [15:0] r16_t;

    // A register pair viewed as two bytes; index with R16_MSB / R16_LSB.
    typedef logic [1:0][7:0] r8_16_t;
    localparam int R16_MSB = 1;
    localparam int R16_LSB = 0;

    // Pair slots inside the register file, in B/C, D/E, H/L order.
    localparam int PAIR_BC    = 0;
    localparam int PAIR_DE    = 1;
    localparam int PAIR_HL    = 2;
    localparam int PAIR_COUNT = 3;

    typedef struct packed {
        logic ir;
        logic ie;
        logic a;
        logic f;
        logic gp8;
        logic gp16;
        logic pc;
        logic sp;
    } reg_wen_vec_t;

    // Byte selector: even codes hit the pair msb, odd codes the lsb.
    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5
    } gp_r8_sel_t;

    typedef enum logic [1:0] {
        REG_BC = 2'd0,
        REG_DE = 2'd1,
        REG_HL = 2'd2
    } gp_r16_sel_t;

    // Flag register: z/n/h/c in the upper nibble, lower nibble always zero.
    typedef struct packed {
        logic       z;
        logic       n;
        logic       h;
        logic       c;
        logic [3:0] pad;
    } flags_t;

    typedef enum logic [1:0] {
        IDU_NONE = 2'd0,
        IDU_INC  = 2'd1,
        IDU_DEC  = 2'd2
    } idu_op_t;

    typedef enum logic [2:0] {
        IDU_PC = 3'd0,
        IDU_SP = 3'd1,
        IDU_BC = 3'd2,
        IDU_DE = 3'd3,
        IDU_HL = 3'd4
    } idu_tgt_t;

    typedef struct packed {
        r8_t    ir;
        r8_t    ie;
        r8_t    a;
        flags_t f;
        r8_16_t b_c;
        r8_16_t d_e;
        r8_16_t h_l;
        r16_t   pc;
        r16_t   sp;
    } reg_vec_t;

endpackage

// File: rtl/sm83_idu.sv
// 16-bit increment/decrement unit; wraps modulo 2^16, never touches flags.
module sm83_idu
    import sm83_pkg::*;
(
    input  r16_t    value,
    input  idu_op_t op,
    output r16_t    result
);

    // Pure combinational +1 / -1; any other op passes the value through.
    always_comb begin
        result = value;
        case (op)
            IDU_INC: result = value + 16'd1;
            IDU_DEC: result = value - 16'd1;
            default: result = value;
        endcase
    end

endmodule

// File: rtl/sm83_regfile.sv
// SM83 architectural register file with a shared IDU for PC/SP/pair
// inc/dec. All state is registered; explicit writes beat the IDU.
module sm83_regfile
    import sm83_pkg::*;
#(
    parameter r16_t RST_PC = 16'h0000,
    parameter r16_t RST_SP = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  reg_wen_vec_t wen,
    input  gp_r8_sel_t   gp8_sel,
    input  gp_r16_sel_t  gp16_sel,
    input  r8_t          wdata8,
    input  r16_t         wdata16,
    input  flags_t       f_wdata,
    input  logic [3:0]   f_wmask,
    input  idu_op_t      idu_op,
    input  idu_tgt_t     idu_tgt,
    output r16_t         idu_addr,
    output reg_vec_t     regs
);

    r8_t    ir_reg, ir_next;
    r8_t    ie_reg, ie_next;
    r8_t    a_reg, a_next;
    flags_t f_reg, f_next;
    r8_16_t pair_reg  [PAIR_COUNT];
    r8_16_t pair_next [PAIR_COUNT];
    r16_t   pc_reg, pc_next;
    r16_t   sp_reg, sp_next;

    r16_t   idu_value;
    r16_t   idu_result;
    logic   idu_active;

    logic [3:0] flag_bits_reg;
    logic [3:0] flag_bits_wdata;
    logic [3:0] flag_bits_next;

    assign idu_active = (idu_op == IDU_INC) || (idu_op == IDU_DEC);

    // Select the IDU source; unused target codes read as zero.
    always_comb begin
        idu_value = '0;
        case (idu_tgt)
            IDU_PC:  idu_value = pc_reg;
            IDU_SP:  idu_value = sp_reg;
            IDU_BC:  idu_value = pair_reg[PAIR_BC];
            IDU_DE:  idu_value = pair_reg[PAIR_DE];
            IDU_HL:  idu_value = pair_reg[PAIR_HL];
            default: idu_value = '0;
        endcase
    end

    assign idu_addr = idu_value;

    sm83_idu u_idu (
        .value  (idu_value),
        .op     (idu_op),
        .result (idu_result)
    );

    assign ir_next = wen.ir ? wdata8 : ir_reg;
    assign ie_next = wen.ie ? wdata8 : ie_reg;
    assign a_next  = wen.a  ? wdata8 : a_reg;

    // Flags are masked individually; the pad nibble is rebuilt as zero.
    assign flag_bits_reg   = {f_reg.z, f_reg.n, f_reg.h, f_reg.c};
    assign flag_bits_wdata = {f_wdata.z, f_wdata.n, f_wdata.h, f_wdata.c};

    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
        assign flag_bits_next[gi] = (wen.f && f_wmask[gi]) ? flag_bits_wdata[gi]
                                                           : flag_bits_reg[gi];
    end

    assign f_next = flags_t'({flag_bits_next, 4'h0});

    // Per-pair merge: gp8 byte over gp16 word; any explicit hit drops the IDU.
    for (genvar gi = 0; gi < PAIR_COUNT; gi++) begin : g_pair
        logic gp16_hit;
        logic msb_hit;
        logic lsb_hit;
        logic idu_take;
        r8_t  msb_next;
        r8_t  lsb_next;

        assign gp16_hit = wen.gp16 && (gp16_sel == 2'(gi));
        assign msb_hit  = wen.gp8 && (gp8_sel == 3'(2 * gi));
        assign lsb_hit  = wen.gp8 && (gp8_sel == 3'(2 * gi + 1));
        assign idu_take = idu_active && (idu_tgt == 3'(int'(IDU_BC) + gi))
                          && !(gp16_hit || msb_hit || lsb_hit);

        assign msb_next = msb_hit  ? wdata8 :
                          gp16_hit ? wdata16[15:8] :
                          idu_take ? idu_result[15:8] :
                                     pair_reg[gi][R16_MSB];
        assign lsb_next = lsb_hit  ? wdata8 :
                          gp16_hit ? wdata16[7:0] :
                          idu_take ? idu_result[7:0] :
                                     pair_reg[gi][R16_LSB];

        assign pair_next[gi] = {msb_next, lsb_next};
    end

    assign pc_next = wen.pc ? wdata16 :
                     (idu_active && idu_tgt == IDU_PC) ? idu_result : pc_reg;
    assign sp_next = wen.sp ? wdata16 :
                     (idu_active && idu_tgt == IDU_SP) ? idu_result : sp_reg;

    // State update; reset overrides every write and IDU op in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_reg <= '0;
            ie_reg <= '0;
            a_reg  <= '0;
            f_reg  <= '0;
            pc_reg <= RST_PC;
            sp_reg <= RST_SP;
            for (int i = 0; i < PAIR_COUNT; i++) begin
                pair_reg[i] <= '0;
            end
        end else begin
            ir_reg <= ir_next;
            ie_reg <= ie_next;
            a_reg  <= a_next;
            f_reg  <= f_next;
            pc_reg <= pc_next;
            sp_reg <= sp_next;
            for (int i = 0; i < PAIR_COUNT; i++) begin
                pair_reg[i] <= pair_next[i];
            end
        end
    end

    // Present the registered state as one bundle.
    always_comb begin
        regs     = '0;
        regs.ir  = ir_reg;
        regs.ie  = ie_reg;
        regs.a   = a_reg;
        regs.f   = f_reg;
        regs.b_c = pair_reg[PAIR_BC];
        regs.d_e = pair_reg[PAIR_DE];
        regs.h_l = pair_reg[PAIR_HL];
        regs.pc  = pc_reg;
        regs.sp  = sp_reg;
    end

endmodule
